// File: rtl/logic_unit_serial_pkg.sv
// Shared definitions for the serial bitwise logic unit: opcodes, FSM
// state encodings and a counter-width helper.
package logic_unit_serial_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_NOTA = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Chunk index width: ceil(log2(n)), never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_serial_slice.sv
// Combinational CHUNK-bit slice applying one of the eight bitwise ops.
module logic_slice
  import logic_unit_serial_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [2:0]       op,
  output logic [CHUNK-1:0] y
);

  // Opcode decode; every code is defined, NOTA ignores b.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: latches operands, processes CHUNK bits
// per clock through one shared slice, then holds the result behind a
// valid/ready handshake together with a zero flag.
module logic_unit_serial
  import logic_unit_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             nz_q, nz_d;
  logic             zero_q, zero_d;
  logic             load;

  logic [CHUNK-1:0] a_chunk, b_chunk, y_chunk;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  logic_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (a_chunk),
    .b  (b_chunk),
    .op (op_q),
    .y  (y_chunk)
  );

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign Y         = res_q;
  assign ZERO      = zero_q;
  assign load      = (state_q == ST_IDLE) && IN_VALID;

  // Next-state: sequence chunks, assemble the result, fold in the zero flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    nz_d    = nz_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          state_d = ST_RUN;
          idx_d   = '0;
          res_d   = '0;
          nz_d    = 1'b0;
        end
      end
      ST_RUN: begin
        res_d[idx_q*CHUNK +: CHUNK] = y_chunk;
        nz_d = nz_q | (|y_chunk);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          // Registered here so ZERO comes straight from a flop in DONE.
          zero_d  = ~(nz_q | (|y_chunk));
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      nz_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      nz_q    <= nz_d;
      zero_q  <= zero_d;
      if (load) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= OP;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_serial.sv
// Self-checking bench: whole-word behavioural model for the default
// configuration plus directed cases for the single-cycle and narrow builds.
module tb_logic_unit_serial;

  logic CLK, RST;

  // default build: WIDTH=32, CHUNK=8
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, ZERO;
  logic [31:0] A, B, Y;
  logic [2:0]  OP;
  // single-cycle build: WIDTH=32, CHUNK=32
  logic        IN_VALID1, IN_READY1, OUT_VALID1, OUT_READY1, ZERO1;
  logic [31:0] A1, B1, Y1;
  logic [2:0]  OP1;
  // narrow build: WIDTH=16, CHUNK=4
  logic        IN_VALID2, IN_READY2, OUT_VALID2, OUT_READY2, ZERO2;
  logic [15:0] A2, B2, Y2;
  logic [2:0]  OP2;

  logic_unit_serial #(.WIDTH(32), .CHUNK(8)) dut0 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OP(OP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .ZERO(ZERO));

  logic_unit_serial #(.WIDTH(32), .CHUNK(32)) dut1 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID1), .IN_READY(IN_READY1),
    .A(A1), .B(B1), .OP(OP1), .OUT_VALID(OUT_VALID1), .OUT_READY(OUT_READY1),
    .Y(Y1), .ZERO(ZERO1));

  logic_unit_serial #(.WIDTH(16), .CHUNK(4)) dut2 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID2), .IN_READY(IN_READY2),
    .A(A2), .B(B2), .OP(OP2), .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY2),
    .Y(Y2), .ZERO(ZERO2));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a | b);
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return ~a;
    endcase
  endfunction

  // Behavioural model of dut0: idle / busy for NCHUNK cycles / holding.
  int          m_phase = 0;   // 0 idle, 1 busy, 2 holding result
  int          m_cnt   = 0;
  logic [31:0] m_res   = '0;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (IN_VALID) begin
             m_phase <= 1;
             m_cnt   <= 4;
             m_res   <= ref_op(A, B, OP);
           end
        1: begin
             if (m_cnt == 1) m_phase <= 2;
             m_cnt <= m_cnt - 1;
           end
        default: if (OUT_READY) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle compare of dut0 against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, IN_READY}, {31'd0, m_phase == 0});
      chk("out_valid", {31'd0, OUT_VALID}, {31'd0, m_phase == 2});
      if (m_phase == 2) begin
        chk("y", Y, m_res);
        chk("zero", {31'd0, ZERO}, {31'd0, m_res == 32'd0});
      end
    end
  end

  // Launch one op on dut0 and wait for its result; lat = cycles after accept.
  task automatic issue0(input logic [31:0] a, b, input logic [2:0] op, output int lat);
    int g = 0;
    while (!IN_READY && g < 50) begin @(negedge CLK); g++; end
    A = a; B = b; OP = op; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    lat = 0;
    while (!OUT_VALID && lat < 50) begin @(negedge CLK); lat++; end
  endtask

  task automatic release0();
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  initial begin
    int lat;
    RST = 1'b1;
    IN_VALID = 0; OUT_READY = 0; A = 0; B = 0; OP = 0;
    IN_VALID1 = 0; OUT_READY1 = 0; A1 = 0; B1 = 0; OP1 = 0;
    IN_VALID2 = 0; OUT_READY2 = 0; A2 = 0; B2 = 0; OP2 = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_y", Y, 32'h0);
    chk("rst_zero", {31'd0, ZERO}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_y2", {16'd0, Y2}, 32'h0);
    RST = 1'b0;
    chk_en = 1'b1;

    // NOR
    issue0(32'h0000FFFF, 32'h00FF00FF, 3'd2, lat);
    chk("nor_lat", lat, 32'd4);
    chk("nor_y", Y, 32'hFF000000);
    chk("nor_zero", {31'd0, ZERO}, 32'd0);
    release0();

    // XOR to zero
    issue0(32'hDEADBEEF, 32'hDEADBEEF, 3'd3, lat);
    chk("xor_y", Y, 32'h0);
    chk("xor_zero", {31'd0, ZERO}, 32'd1);
    release0();

    // Backpressure with toggling inputs
    issue0(32'h12340000, 32'h00005678, 3'd1, lat);
    for (int i = 0; i < 5; i++) begin
      A = $urandom; B = $urandom; OP = 3'($urandom); IN_VALID = 1'b1;
      @(negedge CLK);
      chk("bp_y", Y, 32'h12345678);
      chk("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
    end
    IN_VALID = 1'b0;
    release0();
    chk("bp_ready_after", {31'd0, IN_READY}, 32'd1);

    // Reset mid-RUN after two chunks of an AND
    A = 32'hFFFFFFFF; B = 32'h12345678; OP = 3'd0; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mr_y", Y, 32'h0);
    chk("mr_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("mr_in_ready", {31'd0, IN_READY}, 32'd1);
    issue0(32'hFFFFFFFF, 32'h0F0F0F0F, 3'd4, lat);
    chk("nand_y", Y, 32'hF0F0F0F0);
    release0();

    // Single-cycle build: ANDN
    A1 = 32'hF0F0F0F0; B1 = 32'hFF00FF00; OP1 = 3'd6; IN_VALID1 = 1'b1;
    @(negedge CLK);
    IN_VALID1 = 1'b0;
    lat = 0;
    while (!OUT_VALID1 && lat < 50) begin @(negedge CLK); lat++; end
    chk("c32_lat", lat, 32'd1);
    chk("c32_y", Y1, 32'h00F000F0);
    chk("c32_zero", {31'd0, ZERO1}, 32'd0);
    OUT_READY1 = 1'b1; @(negedge CLK); OUT_READY1 = 1'b0;
    chk("c32_ready", {31'd0, IN_READY1}, 32'd1);

    // Narrow build: NOTA then XNOR
    A2 = 16'h1234; B2 = 16'hFFFF; OP2 = 3'd7; IN_VALID2 = 1'b1;
    @(negedge CLK);
    IN_VALID2 = 1'b0;
    lat = 0;
    while (!OUT_VALID2 && lat < 50) begin @(negedge CLK); lat++; end
    chk("n16_lat", lat, 32'd4);
    chk("n16_nota", {16'd0, Y2}, 32'h0000EDCB);
    OUT_READY2 = 1'b1; @(negedge CLK); OUT_READY2 = 1'b0;
    A2 = 16'hAAAA; B2 = 16'h5555; OP2 = 3'd5; IN_VALID2 = 1'b1;
    @(negedge CLK);
    IN_VALID2 = 1'b0;
    lat = 0;
    while (!OUT_VALID2 && lat < 50) begin @(negedge CLK); lat++; end
    chk("n16_xnor", {16'd0, Y2}, 32'h0);
    chk("n16_zero", {31'd0, ZERO2}, 32'd1);
    OUT_READY2 = 1'b1; @(negedge CLK); OUT_READY2 = 1'b0;

    // Random traffic on the default build, checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      RST       = ($urandom_range(0, 79) == 0);
      IN_VALID  = ($urandom_range(0, 2) != 0);
      OUT_READY = ($urandom_range(0, 2) == 0);
      A  = $urandom;
      B  = ($urandom_range(0, 7) == 0) ? A : $urandom;
      OP = 3'($urandom);
      @(negedge CLK);
    end
    RST = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_serial.md
# logic_unit_serial

Parametrised, multi-cycle bitwise logic unit and the successor to the fixed 32-bit single-function gate arrays. It applies one of eight selectable bitwise operations to two WIDTH-bit operands, CHUNK bits per clock. The result is held in an output register behind a valid/ready handshake, and the unit reports a zero flag. It sits beside the ALU in the processor datapath and lets area be traded against latency through CHUNK.

## Interface
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits processed per cycle. WIDTH % CHUNK must be 0; CHUNK = WIDTH gives a single-cycle run.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- IN_VALID  input  1  operands and opcode presented.
- IN_READY  output  1  unit can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- OP  input  3  opcode.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer accepts the result.
- Y  output  WIDTH  result.
- ZERO  output  1  result is all zeros.

## Operation
- Opcodes:
  - 0: AND
  - 1: OR
  - 2: NOR
  - 3: XOR
  - 4: NAND
  - 5: XNOR
  - 6: ANDN, A & ~B
  - 7: NOTA, ~A (B ignored)
  - All eight codes are defined; there is no illegal opcode.
- NCHUNK = WIDTH/CHUNK. The chunk index counter is ceil(log2(NCHUNK)) bits wide, minimum 1.
- FSM states and transitions:
  - IDLE: IN_READY=1. On IN_VALID, latch A, B and OP, clear the result register, set chunk index to 0, then go to RUN.
  - RUN: each cycle, compute chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) from the latched operands and write it into the same bit range of the result register. OR the chunk bits into a nonzero accumulator. When idx = NCHUNK-1, go to DONE; otherwise increment idx.
  - DONE: OUT_VALID=1. Y and ZERO are held stable. On OUT_READY, go to IDLE.
- Y shows the result register at all times. Partial contents during RUN are not meaningful.
- ZERO = ~nonzero accumulator. It is only meaningful while OUT_VALID=1.
- Input ports are not sampled outside IDLE. Changes to A, B or OP during RUN or DONE have no effect.
- OUT_READY outside DONE is ignored.
- In DONE with OUT_READY=1 and IN_VALID=1, the new operation is not accepted that cycle (IN_READY=0). It is accepted in the following IDLE cycle.
- Reset, including mid-RUN or mid-DONE:
  - state returns to IDLE and the in-flight operation is discarded;
  - Y=0, ZERO=0, OUT_VALID=0, IN_READY=1 from the first cycle after the reset edge;
  - chunk index and latched operands are cleared to 0.

## Timing
- An operation is accepted at edge E0, the edge where IN_VALID and IN_READY are both high.
- RUN occupies edges E1..E_NCHUNK. OUT_VALID rises after E_NCHUNK, i.e. NCHUNK cycles after acceptance.
- Best-case throughput is one operation per NCHUNK+2 cycles: accept, NCHUNK RUN cycles, one DONE cycle.
- Back-to-back operation requires OUT_READY=1 in the first DONE cycle and IN_VALID held high.
- IN_READY and OUT_VALID are registered-state decodes with no combinational path from inputs.
- Y and ZERO are driven directly from registers.

## Structure
- Shared definitions package holds the opcode constants, listed above.
- One sub-module, logic_slice. It is combinational and parametrised by CHUNK, with inputs (a, b, op) and output y implementing the eight opcodes. It is instantiated once and fed from the muxed chunk of the latched operands.
- FSM, chunk counter, operand/result registers and zero accumulator live in logic_unit_serial.

## Test plan
- NOR, WIDTH=32, CHUNK=8:
  - Stimulus: A=0x0000FFFF, B=0x00FF00FF, OP=2.
  - Response: Y=0xFF000000, ZERO=0. OUT_VALID rises exactly 4 cycles after acceptance; IN_READY=0 throughout.
- XOR to zero:
  - Stimulus: A=B=0xDEADBEEF, OP=3.
  - Response: Y=0x00000000, ZERO=1.
- Backpressure:
  - Stimulus: complete OR of 0x12340000 and 0x00005678, then hold OUT_READY=0 for 5 cycles while A, B and OP toggle.
  - Response: Y stays 0x12345678, OUT_VALID stays 1, IN_READY stays 0. After OUT_READY=1 for one cycle, IN_READY=1 the next cycle.
- Reset mid-RUN:
  - Stimulus: assert RST for one cycle after 2 chunks of an AND.
  - Response: next cycle Y=0, OUT_VALID=0, IN_READY=1. A following NAND of 0xFFFFFFFF and 0x0F0F0F0F gives 0xF0F0F0F0.
- Single-cycle configuration, CHUNK=32:
  - Stimulus: ANDN, A=0xF0F0F0F0, B=0xFF00FF00.
  - Response: Y=0x00F000F0, OUT_VALID 1 cycle after acceptance.
- Narrow configuration, WIDTH=16, CHUNK=4:
  - Stimulus: NOTA, A=0x1234, B=0xFFFF.
  - Response: Y=0xEDCB after 4 RUN cycles. A following XNOR of 0xAAAA and 0x5555 gives Y=0x0000, ZERO=1.
